// File: rtl/switch_input_ctrl.sv
// Switch-entry front end: syncs/debounces submit and clear, captures sw, and issues exactly one
// write per entry to the switch register. Define SWCTRL_TIMEOUT_EN to drop entries stuck waiting.
module switch_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic        btn_submit,
  input  logic        btn_clear,
  input  logic        reg_ready,
  output logic [31:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : gen_param_check
    $error("switch_input_ctrl: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  // Bit 0 is submit, bit 1 is clear throughout.
  logic [15:0] sw_s1_q, sw_s2_q;
  logic [1:0]  btn_s1_q, btn_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= {btn_clear, btn_submit};
      btn_s2_q <= btn_s1_q;
    end
  end

  logic [1:0]     db_lvl_q, db_lvl_d;
  logic [1:0]     db_ev_q, db_ev_d;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];

  always_comb begin
    db_lvl_d = db_lvl_q;
    db_ev_d  = '0;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_lvl_d[i] = btn_s2_q[i];
          db_ev_d[i]  = btn_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl_q    <= '0;
      db_ev_q     <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      db_lvl_q    <= db_lvl_d;
      db_ev_q     <= db_ev_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  logic sub_ev, clr_ev;
  assign sub_ev = db_ev_q[0];
  assign clr_ev = db_ev_q[1];

  logic [1:0]  state_q, state_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        ovr_q, ovr_d;

`ifdef SWCTRL_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           tmo_q, tmo_d;
`endif

  always_comb begin
    state_d   = state_q;
    wr_data_d = wr_data_q;
    ovr_d     = ovr_q;
`ifdef SWCTRL_TIMEOUT_EN
    tmo_d     = tmo_q;
    to_cnt_d  = '0;
`endif
    case (state_q)
      StWait: begin
        if (clr_ev) begin
          state_d = StIdle;
          ovr_d   = 1'b0;
`ifdef SWCTRL_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end else if (sub_ev) begin
          // Latest entry wins; the timeout restarts via the zero default.
          ovr_d     = 1'b1;
          wr_data_d = sw_s2_q;
        end else if (reg_ready) begin
          state_d = StWrite;
`ifdef SWCTRL_TIMEOUT_EN
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
          tmo_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        // Idle and the write cycle behave alike: the strobe is already registered.
        state_d = StIdle;
        if (clr_ev) begin
          ovr_d = 1'b0;
`ifdef SWCTRL_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
        end else if (sub_ev) begin
          wr_data_d = sw_s2_q;
          state_d   = StWait;
        end
      end
    endcase
  end

  assign wr_en_d = (state_d == StWrite);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef SWCTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign err_timeout = tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign wr_data     = {16'h0000, wr_data_q};
  assign wr_en       = wr_en_q;
  assign busy        = (state_q != StIdle);
  assign err_overrun = ovr_q;

endmodule

// File: doc/switch_input_ctrl.md
Name: switch_input_ctrl

Overview:
Front-end sequencer for the memory-mapped switch data register.
- Synchronises and debounces the board submit/clear buttons and captures the 16 slide switches.
- Waits for the register's ready flag, then issues exactly one write-enable pulse with the captured value.
- Sits between board I/O and the switch register's data/write_enable/flag ports, so the CPU only ever sees complete, single-shot entries.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before a button level change is accepted (min 1).
- TIMEOUT_CYCLES, 50000000: cycles allowed in WAIT_READY before the pending entry is dropped; used only with SWCTRL_TIMEOUT_EN (min 1).

Ports:
- clk  in  1  system clock, the single clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  16  raw slide switches, asynchronous.
- btn_submit  in  1  raw submit button, asynchronous, active-high.
- btn_clear  in  1  raw clear button, asynchronous, active-high.
- reg_ready  in  1  switch register flag; 1 = register empty; synchronous to clk.
- wr_data  out  32  data to the switch register: {16'h0000, captured sw}.
- wr_en  out  1  one-cycle write strobe to the switch register.
- busy  out  1  1 while an entry is pending (state != IDLE).
- err_overrun  out  1  sticky: a submit arrived while an entry was already pending.
- err_timeout  out  1  sticky: a pending entry was dropped by timeout.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; wr_data=0; wr_en=0; busy=0; both err flags 0; debounced levels 0; all counters 0.
- Synchronisers: sw, btn_submit and btn_clear each pass through a 2-flop synchroniser. reg_ready is not synchronised.
- Debounce, per button:
  - Counter clears whenever the synced input equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while the input still differs, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle event: sub_ev or clr_ev.
  - Raw press to event: 2 + DEBOUNCE_CYCLES cycles.
- Switches are not debounced. Capture value = synced sw in the sub_ev cycle.
- All outputs are registered. wr_data holds the last captured value between writes and does not change during WRITE.
- FSM, priority clr_ev > sub_ev > reg_ready:
  - IDLE: on clr_ev, clear both err flags and stay. On sub_ev, capture into wr_data and go WAIT_READY.
  - WAIT_READY: on clr_ev, drop the entry, clear both err flags, go IDLE; no write occurs. On sub_ev, set err_overrun, overwrite wr_data with the new capture (latest wins), restart the timeout counter, stay. On reg_ready=1, go WRITE.
  - WRITE: wr_en=1 for this one cycle only; next state IDLE unconditionally. A sub_ev in this cycle is captured and goes to WAIT_READY, not IDLE, so no event is lost. A clr_ev in this cycle does not cancel the write already issued; it only clears the err flags.
- Timing: sub_ev at edge N → WAIT_READY from N+1. With reg_ready=1 → wr_en high during cycle N+2 only.
- Back-to-back: after a write, reg_ready falls one cycle later. A new entry waits in WAIT_READY until the CPU read sets reg_ready=1 again.
- busy = (state != IDLE).
- Without SWCTRL_TIMEOUT_EN, err_timeout is tied 0.
- Reset mid-operation: returns immediately to the reset values; a pending entry is discarded and wr_en deasserts asynchronously.
- Counter widths are sized from the parameters. Counters never wrap: debounce clears on a flip; timeout clears on state exit.

Optional Feature:
SWCTRL_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_READY, cleared on entry and on overrun replacement.
  - If it reaches TIMEOUT_CYCLES-1 with reg_ready=0: set err_timeout, drop the entry, go IDLE.
  - If reg_ready=1 in that same cycle, the write wins and no timeout is flagged.
- Undefined: WAIT_READY waits indefinitely; no timeout counter is built; err_timeout=0.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
1. Reset, then sw=16'hA5C3, reg_ready=1, btn_submit held 10 cycles → exactly one wr_en pulse, wr_data=32'h0000A5C3, wr_en 8 cycles after the press sampled (2 sync + 4 debounce + 2 FSM), busy high 2 cycles.
2. btn_submit glitch: high 3 cycles, low 3 cycles, repeated 5 times → no sub_ev, wr_en never asserts, busy stays 0.
3. reg_ready=0; submit sw=16'h0011, then submit sw=16'h0022; then reg_ready=1 → err_overrun=1, single write of 32'h00000022.
4. reg_ready=0; submit sw=16'h1234; press btn_clear → busy=0, err flags 0, no wr_en even after reg_ready=1.
5. With SWCTRL_TIMEOUT_EN, reg_ready=0; submit, hold 20 cycles → err_timeout=1 after 16 cycles in WAIT_READY, busy=0, no wr_en; a later clear resets err_timeout.
6. rst_n pulsed low while in WAIT_READY with wr_data=32'h00005555 → all outputs 0 immediately; after release, reg_ready=1 produces no write.
